// File: rtl/cls_arbiter.sv
// Packet-level round-robin arbiter feeding one registered SPI byte buffer.
// Optional idle-timeout release is built when CLS_ARB_TIMEOUT_EN is defined.
module cls_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_last,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       abort
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic       last_served_q, last_served_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_last_q, tx_last_d;

    logic       buf_free;
    logic       acc0, acc1, acc;
    logic       acc_last;
    logic [7:0] acc_data;
    logic       timeout;

    assign buf_free   = !tx_valid_q || tx_ready;
    assign req0_ready = (state_q == GNT0) && buf_free;
    assign req1_ready = (state_q == GNT1) && buf_free;
    assign acc0       = req0_ready && req0_valid;
    assign acc1       = req1_ready && req1_valid;
    assign acc        = acc0 || acc1;
    assign acc_last   = acc1 ? req1_last : req0_last;
    assign acc_data   = acc1 ? req1_data : req0_data;

    assign grant    = {state_q == GNT1, state_q == GNT0};
    assign tx_data  = tx_data_q;
    assign tx_last  = tx_last_q;
    assign tx_valid = tx_valid_q;

`ifdef CLS_ARB_TIMEOUT_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [7:0] idle_cnt_inc;

    assign idle_cnt_inc = idle_cnt_q + 8'd1;

    // Counts consecutive granted cycles without an accepted byte.
    always_comb begin
        idle_cnt_d = 8'd0;
        timeout    = 1'b0;
        if ((state_q != IDLE) && !acc) begin
            if (idle_cnt_inc == 8'(TIMEOUT)) begin
                timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_q <= 8'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign abort = timeout;
`else
    assign timeout = 1'b0;
    assign abort   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        tx_last_d     = tx_last_q;

        if (acc) begin
            tx_valid_d = 1'b1;
            tx_data_d  = acc_data;
            tx_last_d  = acc_last;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (req0_valid && (!req1_valid || last_served_q)) begin
                    state_d = GNT0;
                end else if (req1_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if ((acc0 && acc_last) || timeout) begin
                    state_d       = IDLE;
                    last_served_d = 1'b0;
                end
            end
            GNT1: begin
                if ((acc1 && acc_last) || timeout) begin
                    state_d       = IDLE;
                    last_served_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            tx_last_q     <= tx_last_d;
        end
    end

endmodule

// File: tb/tb_cls_arbiter.sv
// Scoreboard bench for cls_arbiter: directed packets, expected bytes queued
// up front and popped by a monitor on every tx handshake.
module tb_cls_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] tx_data;
    logic       tx_last, tx_valid, tx_ready;
    logic [1:0] grant;
    logic       abort;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    logic [7:0] pc[$];
    logic [1:0] prev_grant = 2'b00;
    logic       switch_err = 1'b0;
    logic       req1_done;

    logic [1:0] g1[7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    logic       v1[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       r3[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       tr[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] g4[7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
`ifdef CLS_ARB_TIMEOUT_EN
    logic [1:0] g5[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
    logic       a5[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    logic [1:0] g5[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic       a5[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    always #5 clock = ~clock;

    cls_arbiter #(.TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .grant      (grant),
        .abort      (abort)
    );

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tx_unexpected: got %0h last %0b, want none",
                         tx_data, tx_last);
            end else begin
                check("tx_byte", {tx_last, tx_data}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (prev_grant != 2'b00 && grant != 2'b00 && grant != prev_grant)
            switch_err = 1'b1;
        prev_grant = grant;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int n, input logic v, input logic [7:0] d,
                         input logic l);
        if (n == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    task automatic expect_pkt(input logic [7:0] d[$], input logic wl);
        int sz;
        sz = d.size();
        for (int i = 0; i < sz; i++)
            exp_q.push_back({wl && (i == sz - 1), d[i]});
    endtask

    task automatic send(input int n, input logic [7:0] d[$], input logic wl);
        int   sz;
        int   budget;
        logic done;
        logic rdy;
        sz = d.size();
        for (int i = 0; i < sz; i++) begin
            drive(n, 1'b1, d[i], wl && (i == sz - 1));
            done = 1'b0;
            budget = 0;
            while (!done) begin
                @(negedge clock);
                rdy = (n == 0) ? req0_ready : req1_ready;
                tick();
                if (rdy) begin
                    done = 1'b1;
                end else begin
                    budget++;
                    if (budget > 60) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL send_timeout: req%0d byte %0h, got no ready, want ready",
                                 n, d[i]);
                        drive(n, 1'b0, 8'h00, 1'b0);
                        return;
                    end
                end
            end
        end
        drive(n, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            tick();
            b++;
        end
        check("drain_empty", 9'(exp_q.size()), 9'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        tx_ready = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        @(negedge clock);
        check("rst_grant", 9'(grant), 9'd0);
        check("rst_tx_valid", 9'(tx_valid), 9'd0);
        check("rst_tx_data", 9'(tx_data), 9'd0);
        check("rst_tx_last", 9'(tx_last), 9'd0);
        check("rst_abort", 9'(abort), 9'd0);
        check("rst_ready0", 9'(req0_ready), 9'd0);
        tick();
        reset = 1'b0;
        tick();

        // single packet with grant and tx_valid timing
        pa = '{8'h1B, 8'h5B, 8'h30, 8'h6A};
        expect_pkt(pa, 1'b1);
        fork
            send(0, pa, 1'b1);
            for (int k = 0; k < 7; k++) begin
                @(negedge clock);
                check("p1_grant", 9'(grant), 9'(g1[k]));
                check("p1_tx_valid", 9'(tx_valid), 9'(v1[k]));
            end
        join
        tick();
        drain();

        // tie from reset, then round-robin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pa = '{8'h11, 8'h12};
        pb = '{8'h21, 8'h22};
        pc = '{8'h13, 8'h14};
        expect_pkt(pa, 1'b1);
        expect_pkt(pb, 1'b1);
        expect_pkt(pc, 1'b1);
        fork
            begin
                send(0, pa, 1'b1);
                send(0, pc, 1'b1);
            end
            send(1, pb, 1'b1);
        join
        drain();

        // back-pressure on a req1 packet
        pa = '{8'h41, 8'h3A, 8'h20};
        expect_pkt(pa, 1'b1);
        fork
            send(1, pa, 1'b1);
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                check("bp_ready1", 9'(req1_ready), 9'(r3[k]));
                if (k == 2 || k == 3)
                    check("bp_hold", {tx_valid, tx_data}, 9'h141);
                tick();
                tx_ready = tr[k + 1];
            end
        join
        tx_ready = 1'b1;
        drain();

        // req1 arrives mid req0 packet
        pa = '{8'h51, 8'h52, 8'h53};
        pb = '{8'h61};
        expect_pkt(pa, 1'b1);
        expect_pkt(pb, 1'b1);
        fork
            send(0, pa, 1'b1);
            begin
                tick();
                tick();
                send(1, pb, 1'b1);
            end
            for (int k = 0; k < 7; k++) begin
                @(negedge clock);
                check("mc_grant", 9'(grant), 9'(g4[k]));
            end
        join
        tick();
        drain();

        // stalled packet: timeout release or indefinite hold
        pa = '{8'h01};
        pb = '{8'h71};
        pc = '{8'h02};
        expect_pkt(pa, 1'b0);
`ifndef CLS_ARB_TIMEOUT_EN
        expect_pkt(pc, 1'b1);
`endif
        expect_pkt(pb, 1'b1);
        req1_done = 1'b0;
        fork
            begin
                tick();
                tick();
                send(1, pb, 1'b1);
                req1_done = 1'b1;
            end
        join_none
        fork
            send(0, pa, 1'b0);
            for (int k = 0; k < 8; k++) begin
                @(negedge clock);
                check("to_grant", 9'(grant), 9'(g5[k]));
                check("to_abort", 9'(abort), 9'(a5[k]));
            end
        join
        tick();
`ifndef CLS_ARB_TIMEOUT_EN
        send(0, pc, 1'b1);
`endif
        for (int b = 0; b < 100 && !req1_done; b++)
            tick();
        check("to_req1_done", 9'(req1_done), 9'd1);
        drain();

        // reset mid-packet discards the buffered byte
        pa = '{8'hB0};
        expect_pkt(pa, 1'b1);
        send(0, pa, 1'b1);
        drain();
        tx_ready = 1'b0;
        drive(0, 1'b1, 8'h81, 1'b0);
        tick();
        tick();
        drive(0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("rm_pre_tx", {tx_valid, tx_data}, 9'h181);
        check("rm_pre_grant", 9'(grant), 9'd1);
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("rm_tx_valid", 9'(tx_valid), 9'd0);
        check("rm_grant", 9'(grant), 9'd0);
        tick();
        reset = 1'b0;
        tx_ready = 1'b1;
        pa = '{8'h91};
        pb = '{8'hA1};
        expect_pkt(pa, 1'b1);
        expect_pkt(pb, 1'b1);
        fork
            send(0, pa, 1'b1);
            send(1, pb, 1'b1);
        join
        drain();

        check("no_direct_switch", 9'(switch_err), 9'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
